// File: rtl/iob_fifo_sync_fwft_pkg.sv
// iob_fifo_sync_fwft_pkg: size/width derivations and reset constants for the sync FIFO.
package iob_fifo_sync_fwft_pkg;
    localparam logic RST_EMPTY = 1'b1;
    localparam logic RST_FULL  = 1'b0;
    localparam logic RST_ERR   = 1'b0;

    function automatic int fifo_size(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int lvl_w(input int addr_w);
        return addr_w + 1;
    endfunction
endpackage

// File: rtl/iob_fifo_regfile.sv
// iob_fifo_regfile: 2**ADDR_W x DATA_W register array, one write port, async read port.
module iob_fifo_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              w_en_i,
    input  logic [ADDR_W-1:0] w_addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic [ADDR_W-1:0] r_addr_i,
    output logic [DATA_W-1:0] r_data_o
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk_i)
        if (w_en_i) mem[w_addr_i] <= w_data_i;

    assign r_data_o = mem[r_addr_i];
endmodule

// File: rtl/iob_fifo_sync_fwft.sv
// iob_fifo_sync_fwft: single-clock FIFO with FWFT or registered read, almost flags,
// sticky overflow/underflow and a level output.
module iob_fifo_sync_fwft
    import iob_fifo_sync_fwft_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FWFT   = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cke_i,
    input  logic              w_en_i,
    input  logic [DATA_W-1:0] w_data_i,
    output logic              w_full_o,
    output logic              w_almost_full_o,
    input  logic              r_en_i,
    output logic [DATA_W-1:0] r_data_o,
    output logic              r_empty_o,
    output logic              r_almost_empty_o,
    input  logic [ADDR_W:0]   af_thr_i,
    input  logic [ADDR_W:0]   ae_thr_i,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o,
    output logic              underflow_o,
    input  logic              clr_err_i
);
    localparam int LW = lvl_w(ADDR_W);
    localparam logic [LW-1:0] SIZE = LW'(fifo_size(ADDR_W));

    logic [ADDR_W-1:0] w_ptr, r_ptr;
    logic [LW-1:0]     level, level_nxt;
    logic [DATA_W-1:0] mem_data;
    logic              w_acc, r_acc;

    // flags are the registered ones, so full/empty reject simultaneous through-traffic
    assign w_acc     = cke_i & w_en_i & ~w_full_o;
    assign r_acc     = cke_i & r_en_i & ~r_empty_o;
    assign level_nxt = level + LW'(w_acc) - LW'(r_acc);

    always_ff @(posedge clk_i)
        if (!rst_n_i) begin
            w_ptr       <= '0;
            r_ptr       <= '0;
            level       <= '0;
            r_empty_o   <= RST_EMPTY;
            w_full_o    <= RST_FULL;
            overflow_o  <= RST_ERR;
            underflow_o <= RST_ERR;
        end else if (cke_i) begin
            w_ptr       <= w_ptr + ADDR_W'(w_acc);
            r_ptr       <= r_ptr + ADDR_W'(r_acc);
            level       <= level_nxt;
            r_empty_o   <= level_nxt == '0;
            w_full_o    <= level_nxt == SIZE;
            overflow_o  <= (w_en_i & w_full_o) | (overflow_o & ~clr_err_i);
            underflow_o <= (r_en_i & r_empty_o) | (underflow_o & ~clr_err_i);
        end

    assign level_o          = level;
    assign w_almost_full_o  = level >= af_thr_i;
    assign r_almost_empty_o = level <= ae_thr_i;

    iob_fifo_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_regfile (
        .clk_i    (clk_i),
        .w_en_i   (w_acc),
        .w_addr_i (w_ptr),
        .w_data_i (w_data_i),
        .r_addr_i (r_ptr),
        .r_data_o (mem_data)
    );

    if (FWFT != 0) begin : g_fwft
        assign r_data_o = mem_data;
    end else begin : g_std
        logic [DATA_W-1:0] r_data;
        always_ff @(posedge clk_i)
            if (!rst_n_i) r_data <= '0;
            else if (r_acc) r_data <= mem_data;
        assign r_data_o = r_data;
    end
endmodule

// File: tb/tb_iob_fifo_sync_fwft.sv
// tb_iob_fifo_sync_fwft: table vectors, directed corner cases and random traffic
// checked against a queue-based model; FWFT and standard instances share inputs.
module tb_iob_fifo_sync_fwft;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int CAP = 4;

    logic clk = 0, rst_n = 0, cke = 1, w_en = 0, r_en = 0, clr = 0;
    logic [DW-1:0] w_data = '0;
    logic [AW:0] af_thr = 3'd3, ae_thr = 3'd1;

    logic a_full, a_af, a_empty, a_ae, a_ovf, a_unf;
    logic [DW-1:0] a_rdata;
    logic [AW:0] a_level;
    logic b_full, b_af, b_empty, b_ae, b_ovf, b_unf;
    logic [DW-1:0] b_rdata;
    logic [AW:0] b_level;

    int errors = 0, checks = 0;

    logic [DW-1:0] q[$];
    logic m_ovf = 0, m_unf = 0;
    logic [DW-1:0] m_sd = '0;

    always #5 clk = ~clk;

    iob_fifo_sync_fwft #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .w_en_i(w_en), .w_data_i(w_data),
        .w_full_o(a_full), .w_almost_full_o(a_af), .r_en_i(r_en), .r_data_o(a_rdata),
        .r_empty_o(a_empty), .r_almost_empty_o(a_ae), .af_thr_i(af_thr), .ae_thr_i(ae_thr),
        .level_o(a_level), .overflow_o(a_ovf), .underflow_o(a_unf), .clr_err_i(clr)
    );

    iob_fifo_sync_fwft #(.DATA_W(DW), .ADDR_W(AW), .FWFT(0)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .w_en_i(w_en), .w_data_i(w_data),
        .w_full_o(b_full), .w_almost_full_o(b_af), .r_en_i(r_en), .r_data_o(b_rdata),
        .r_empty_o(b_empty), .r_almost_empty_o(b_ae), .af_thr_i(af_thr), .ae_thr_i(ae_thr),
        .level_o(b_level), .overflow_o(b_ovf), .underflow_o(b_unf), .clr_err_i(clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: FIFO semantics on a queue, using the pre-edge state for acceptance
    task automatic model_edge();
        bit full, empty;
        if (!rst_n) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
            m_sd = '0;
        end else if (cke) begin
            full = q.size() == CAP;
            empty = q.size() == 0;
            m_ovf = (w_en && full) || (m_ovf && !clr);
            m_unf = (r_en && empty) || (m_unf && !clr);
            if (r_en && !empty) m_sd = q.pop_front();
            if (w_en && !full) q.push_back(w_data);
        end
    endtask

    task automatic model_check();
        int lvl = q.size();
        chk("level", 32'(a_level), 32'(lvl));
        chk("empty", 32'(a_empty), 32'(lvl == 0));
        chk("full", 32'(a_full), 32'(lvl == CAP));
        chk("almost_full", 32'(a_af), 32'(lvl >= int'(af_thr)));
        chk("almost_empty", 32'(a_ae), 32'(lvl <= int'(ae_thr)));
        chk("overflow", 32'(a_ovf), 32'(m_ovf));
        chk("underflow", 32'(a_unf), 32'(m_unf));
        if (lvl != 0) chk("fwft_data", 32'(a_rdata), 32'(q[0]));
        chk("std_level", 32'(b_level), 32'(lvl));
        chk("std_data", 32'(b_rdata), 32'(m_sd));
    endtask

    task automatic step(input logic rn, input logic ck, input logic we, input logic re,
                        input logic cl, input logic [DW-1:0] d);
        rst_n = rn; cke = ck; w_en = we; r_en = re; clr = cl; w_data = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    typedef struct {
        logic rn, we, re, cl;
        logic [DW-1:0] d;
        int lvl;
        logic empty, full, ovf, unf;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // fill, overflow, drain, underflow, clear
        tbl[0]  = '{0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00};
        tbl[1]  = '{1, 1, 0, 0, 8'h11, 1, 0, 0, 0, 0, 8'h11};
        tbl[2]  = '{1, 1, 0, 0, 8'h22, 2, 0, 0, 0, 0, 8'h11};
        tbl[3]  = '{1, 1, 0, 0, 8'h33, 3, 0, 0, 0, 0, 8'h11};
        tbl[4]  = '{1, 1, 0, 0, 8'h44, 4, 0, 1, 0, 0, 8'h11};
        tbl[5]  = '{1, 1, 0, 0, 8'h55, 4, 0, 1, 1, 0, 8'h11};
        tbl[6]  = '{1, 0, 1, 0, 8'h00, 3, 0, 0, 1, 0, 8'h22};
        tbl[7]  = '{1, 0, 1, 0, 8'h00, 2, 0, 0, 1, 0, 8'h33};
        tbl[8]  = '{1, 0, 1, 0, 8'h00, 1, 0, 0, 1, 0, 8'h44};
        tbl[9]  = '{1, 0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 8'h00};
        tbl[10] = '{1, 0, 1, 0, 8'h00, 0, 1, 0, 1, 1, 8'h00};
        tbl[11] = '{1, 0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 8'h00};

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rn, 1, tbl[i].we, tbl[i].re, tbl[i].cl, tbl[i].d);
            chk($sformatf("tbl%0d_level", i), 32'(a_level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_empty", i), 32'(a_empty), 32'(tbl[i].empty));
            chk($sformatf("tbl%0d_full", i), 32'(a_full), 32'(tbl[i].full));
            chk($sformatf("tbl%0d_ovf", i), 32'(a_ovf), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_unf", i), 32'(a_unf), 32'(tbl[i].unf));
            if (!tbl[i].empty) chk($sformatf("tbl%0d_rdata", i), 32'(a_rdata), 32'(tbl[i].rd));
        end
        chk("std_reset_rdata_after_drain", 32'(b_rdata), 32'h44);

        // simultaneous read/write at level 2 keeps level and order
        step(1, 1, 1, 0, 0, 8'hA0);
        step(1, 1, 1, 0, 0, 8'hA1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 1, 1, 0, 8'hB0 + 8'(i));
            chk("rw_level2", 32'(a_level), 32'd2);
        end
        chk("rw_order_head", 32'(a_rdata), 32'hB4);
        step(1, 1, 0, 1, 0, 8'h00);
        step(1, 1, 0, 1, 0, 8'h00);
        // simultaneous read/write while empty: only the write lands
        step(1, 1, 1, 1, 0, 8'hC7);
        chk("rw_empty_level", 32'(a_level), 32'd1);
        chk("rw_empty_unf", 32'(a_unf), 32'd1);
        chk("rw_empty_data", 32'(a_rdata), 32'hC7);
        step(1, 1, 0, 1, 1, 8'h00);

        // thresholds af=3 ae=1 across levels 0..4
        chk("ae_at0", 32'(a_ae), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step(1, 1, 1, 0, 0, 8'(i));
            chk($sformatf("af_at%0d", i), 32'(a_af), 32'(i >= 3));
            chk($sformatf("ae_at%0d", i), 32'(a_ae), 32'(i <= 1));
        end
        // threshold above capacity never asserts almost-full
        af_thr = 3'd5;
        #1 chk("af_thr_above_cap", 32'(a_af), 32'd0);
        af_thr = 3'd3;
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0, 8'h00);

        // standard-mode registered read and hold, then pointer wrap
        step(1, 1, 1, 0, 0, 8'hA5);
        chk("std_before_read", 32'(b_rdata), 32'h04);
        step(1, 1, 0, 1, 0, 8'h00);
        chk("std_read_a5", 32'(b_rdata), 32'hA5);
        step(1, 1, 0, 0, 0, 8'h00);
        step(1, 1, 1, 0, 0, 8'h5A);
        chk("std_hold_a5", 32'(b_rdata), 32'hA5);
        step(1, 1, 0, 1, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 1, 0, 0, 8'h60 + 8'(i));
            step(1, 1, 0, 1, 0, 8'h00);
            chk("wrap_std", 32'(b_rdata), 32'(8'h60 + 8'(i)));
        end

        // reset mid-operation at level 3
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 8'hD0 + 8'(i));
        step(0, 1, 1, 1, 0, 8'hEE);
        chk("rst_level", 32'(a_level), 32'd0);
        chk("rst_empty", 32'(a_empty), 32'd1);
        chk("rst_std_data", 32'(b_rdata), 32'd0);
        // cke low freezes level and error flags
        step(1, 1, 1, 0, 0, 8'hF1);
        step(1, 1, 0, 1, 0, 8'h00);
        step(1, 1, 0, 1, 0, 8'h00);
        step(1, 1, 1, 0, 0, 8'hF2);
        step(1, 0, 1, 0, 1, 8'hF3);
        step(1, 0, 0, 1, 1, 8'h00);
        chk("cke_level", 32'(a_level), 32'd1);
        chk("cke_unf_held", 32'(a_unf), 32'd1);
        chk("cke_data", 32'(a_rdata), 32'hF2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (($urandom % 50) == 0) begin
                af_thr = 3'($urandom_range(0, 7));
                ae_thr = 3'($urandom_range(0, 7));
            end
            step(($urandom % 80) != 0, ($urandom % 10) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, ($urandom % 15) == 0, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
